// File: rtl/dpsram_be.sv
// dpsram_be -- dual-port synchronous SRAM with byte-lane write enables.
//
// Two independent read/write ports share one array. Each port has an access
// enable, a write strobe and per-byte lane enables. Reads return either the
// word as it stands after this edge's writes (RDW_MODE=0) or the word as it
// stood before them (RDW_MODE=1), including writes made by the other port.
// When both ports write one address in the same cycle, each lane takes
// port A's data if A enables it, otherwise port B's. After reset, an
// optional clear sequencer zeroes every word before the ports are released.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   init_done           high once the array is usable
//   en_x, we_x          port access enable, write strobe (x = a, b)
//   be_x [NB]           byte-lane write enables
//   addr_x [ADDR_WIDTH] word address
//   data_x [DATA_WIDTH] write data
//   q_x [DATA_WIDTH]    read data, latency 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1)
//   collision           one-cycle pulse after a same-address access that
//                       involves a write, aligned with the first read stage
module dpsram_be #(
    parameter int SIZE           = 4096,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = $clog2(SIZE),
    parameter int OUTPUT_REG     = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_done,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [NB-1:0]         be_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [NB-1:0]         be_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  collision
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    // state is the single observable FSM register for external checkers.
    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;
    logic                    run;

    logic [DATA_WIDTH-1:0]   mem [SIZE];

    logic                    ok_a, ok_b, wr_a, wr_b, same_addr;
    logic [DATA_WIDTH-1:0]   old_a, old_b, fin_a, fin_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0]   r_a, r_b;

    // Addresses past the end of a non-power-of-two array are dead.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < (ADDR_WIDTH+1)'(SIZE));
    endfunction

    assign run = (state == ST_RUN);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            init_done <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == ADDR_WIDTH'(SIZE - 1)) begin
                    state_next   = ST_RUN;
                    clr_cnt_next = '0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- access decode ----------------
    assign ok_a      = in_range(addr_a);
    assign ok_b      = in_range(addr_b);
    assign wr_a      = run && en_a && we_a && ok_a;
    assign wr_b      = run && en_b && we_b && ok_b;
    assign same_addr = (addr_a == addr_b);
    assign old_a     = ok_a ? mem[addr_a] : '0;
    assign old_b     = ok_b ? mem[addr_b] : '0;

    // Word each address holds after this edge: B's lanes first, then A's
    // lanes on top so A wins a doubly-enabled lane.
    always_comb begin
        fin_a = old_a;
        fin_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wr_b && be_b[i] && same_addr)
                fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && be_a[i])
                fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_b && be_b[i])
                fin_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && be_a[i] && same_addr)
                fin_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign rd_a = (RDW_MODE != 0) ? old_a : fin_a;
    assign rd_b = (RDW_MODE != 0) ? old_b : fin_b;

    // Array: contents are never reset, only overwritten by the clear walk.
    // On a shared address both ports store the same merged word.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_b) mem[addr_b] <= fin_b;
            if (wr_a) mem[addr_a] <= fin_a;
        end
    end

    // ---------------- first read stage and collision ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            collision <= 1'b0;
        end else begin
            if (!run) begin
                r_a <= '0;
                r_b <= '0;
            end else begin
                if (en_a) r_a <= rd_a;
                if (en_b) r_b <= rd_b;
            end
            collision <= run && en_a && en_b && same_addr && (we_a || we_b);
        end
    end

    // ---------------- optional output register ----------------
    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] p_a, p_b;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_a <= '0;
                    p_b <= '0;
                end else begin
                    p_a <= r_a;
                    p_b <= r_b;
                end
            end
            assign q_a = p_a;
            assign q_b = p_b;
        end else begin : g_noreg
            assign q_a = r_a;
            assign q_b = r_b;
        end
    endgenerate

endmodule

// File: tb/tb_dpsram_be.sv
// tb_dpsram_be -- drives two instances in lockstep from one stimulus stream:
// dut0 (latency 1, write-first) and dut1 (latency 2, read-first), both
// 16 words of 32 bits with clear-on-reset, against an array-level model.
module tb_dpsram_be;

    localparam int SIZE = 16;
    localparam int DW   = 32;
    localparam int NB   = 4;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en_a, we_a, en_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] q0_a, q0_b, q1_a, q1_b;
    logic          init0, init1, coll0, coll1;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dpsram_be #(.SIZE(SIZE), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                .OUTPUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .init_done(init0),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q0_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q0_b),
        .collision(coll0)
    );

    dpsram_be #(.SIZE(SIZE), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                .OUTPUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .init_done(init1),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q1_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q1_b),
        .collision(coll1)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [SIZE];
    int            clr_left;
    logic [DW-1:0] e_new_a, e_new_b;   // write-first read result
    logic [DW-1:0] e_old_a, e_old_b;   // read-first read result
    logic          e_coll, e_init;
    logic [DW-1:0] exp_qa[$], exp_qb[$]; // dut1 output pipeline
    int            n_tests, n_fail;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = SIZE;
        e_new_a  = '0; e_new_b = '0;
        e_old_a  = '0; e_old_b = '0;
        e_coll   = 1'b0;
        e_init   = 1'b0;
        exp_qa   = {};
        exp_qb   = {};
        exp_qa.push_back('0);
        exp_qb.push_back('0);
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_a, old_b;
        if (!reset_n) return;
        if (clr_left > 0) begin
            m_mem[SIZE - clr_left] = '0;
            clr_left--;
            e_coll = 1'b0;
        end else begin
            old_a = m_mem[addr_a];
            old_b = m_mem[addr_b];
            // Apply B then A so that A's lanes end up on top.
            if (en_b && we_b)
                for (int i = 0; i < NB; i++)
                    if (be_b[i]) m_mem[addr_b][i*8 +: 8] = data_b[i*8 +: 8];
            if (en_a && we_a)
                for (int i = 0; i < NB; i++)
                    if (be_a[i]) m_mem[addr_a][i*8 +: 8] = data_a[i*8 +: 8];
            if (en_a) begin e_new_a = m_mem[addr_a]; e_old_a = old_a; end
            if (en_b) begin e_new_b = m_mem[addr_b]; e_old_b = old_b; end
            e_coll = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
        end
        e_init = (clr_left == 0);
        exp_qa.push_back(e_old_a);
        exp_qb.push_back(e_old_b);
    endtask

    task automatic check_all();
        logic [DW-1:0] pa, pb;
        pa = '0;
        pb = '0;
        if (reset_n) begin
            pa = exp_qa.pop_front();
            pb = exp_qb.pop_front();
        end
        check("m0_q_a", q0_a, e_new_a);
        check("m0_q_b", q0_b, e_new_b);
        check("m1_q_a", q1_a, pa);
        check("m1_q_b", q1_b, pb);
        check("m0_coll", {31'b0, coll0}, {31'b0, e_coll});
        check("m1_coll", {31'b0, coll1}, {31'b0, e_coll});
        check("m0_init", {31'b0, init0}, {31'b0, e_init});
        check("m1_init", {31'b0, init1}, {31'b0, e_init});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; data_a = '0;
        en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; data_b = '0;
    endtask

    task automatic rand_access(input int amax);
        en_a   = 1'($urandom_range(0, 3) != 0);
        we_a   = 1'($urandom_range(0, 1));
        be_a   = NB'($urandom_range(0, 15));
        addr_a = AW'($urandom_range(0, amax));
        data_a = $urandom;
        en_b   = 1'($urandom_range(0, 3) != 0);
        we_b   = 1'($urandom_range(0, 1));
        be_b   = NB'($urandom_range(0, 15));
        addr_b = AW'($urandom_range(0, amax));
        data_b = $urandom;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_idle();
        reset_n = 1'b0;
        model_reset();
        #2;
        check_all();
        step();
        step();
        release_reset();

        // Clear phase with random traffic that must be dropped.
        repeat (SIZE) begin
            rand_access(SIZE - 1);
            step();
        end

        // Every word reads back as zero.
        set_idle();
        for (int i = 0; i < SIZE; i++) begin
            en_a = 1'b1; addr_a = AW'(i);
            step();
            check("clear_rd", q0_a, '0);
        end

        // Byte-lane merge.
        en_a = 1'b1; we_a = 1'b1; be_a = 4'b1111; addr_a = 4'd5; data_a = 32'h11223344;
        step();
        be_a = 4'b0101; data_a = 32'hAABBCCDD;
        step();
        we_a = 1'b0;
        step();
        check("be_merge", q0_a, 32'h11BB33DD);
        set_idle();
        step();
        check("be_merge_p", q1_a, 32'h11BB33DD);

        // Same-port read-during-write.
        en_a = 1'b1; we_a = 1'b1; be_a = 4'b1111; addr_a = 4'd7; data_a = 32'hDEADBEEF;
        step();
        check("rdw_new", q0_a, 32'hDEADBEEF);
        set_idle();
        step();
        check("rdw_old", q1_a, 32'h00000000);

        // Dual-write collision on one address.
        en_a = 1'b1; we_a = 1'b1; be_a = 4'b0011; addr_a = 4'd3; data_a = 32'hAAAAAAAA;
        en_b = 1'b1; we_b = 1'b1; be_b = 4'b0110; addr_b = 4'd3; data_b = 32'hBBBBBBBB;
        step();
        check("dual_q_a", q0_a, 32'h00BBAAAA);
        check("dual_q_b", q0_b, 32'h00BBAAAA);
        check("dual_coll", {31'b0, coll0}, 32'd1);
        set_idle();
        step();
        check("dual_coll_end", {31'b0, coll0}, 32'd0);
        check("dual_m1_old", q1_a, 32'h00000000);
        en_b = 1'b1; addr_b = 4'd3;
        step();
        check("dual_stored", q0_b, 32'h00BBAAAA);

        // Random traffic, narrow address range to force conflicts.
        repeat (400) begin
            rand_access(($urandom_range(0, 1) != 0) ? 3 : SIZE - 1);
            step();
        end

        // Reset mid-run: outputs drop at once.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        set_idle();
        release_reset();

        // Reset mid-clear at count 9, then a full clear again.
        repeat (9) step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        release_reset();
        repeat (SIZE) begin
            rand_access(SIZE - 1);
            step();
        end
        check("reclear_init", {31'b0, init0}, 32'd1);

        repeat (200) begin
            rand_access(3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
